// File: rtl/uart_rx_parity.sv
// UART 8E1 receiver: start, 8 data bits LSB first, even parity, one stop bit.
// Oversampled by s_tick; delivers byte with one-cycle valid strobe and error flags.
module uart_rx_parity #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_bit_q, par_bit_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             rx_meta_q, rx_s_q;

  // Two-flop synchroniser; idle-high reset value avoids a false start after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit to reject glitches
        if (s_tick) begin
          if (tick_cnt_q == TickHalf) begin
            if (!rx_s_q) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (tick_cnt_q == TickLast) begin
            shreg_d    = {rx_s_q, shreg_q[7:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            else bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      S_PARITY: begin
        if (s_tick) begin
          if (tick_cnt_q == TickLast) begin
            par_bit_d  = rx_s_q;
            tick_cnt_d = '0;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (tick_cnt_q == TickLast) begin
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
            parity_err_d = par_bit_q ^ (^shreg_q);
            frame_err_d  = ~rx_s_q;
            state_d      = rx_s_q ? S_IDLE : S_BREAK;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      S_BREAK: begin
        // A held-low line is a break, never a new start bit
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
